// File: rtl/ram_port1_streamer.sv
// Read-only streamer on the OpenRAM 1R port: reads a wrapping run of words into a
// show-ahead FIFO and emits them on valid/ready. Optional checksum: RAM_STREAM_CSUM_EN.
module ram_port1_streamer #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_clk1,
    output logic              ram_csb1,
    output logic [ADDR_W-1:0] ram_addr1,
    input  logic [DATA_W-1:0] ram_dout1,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
`ifdef RAM_STREAM_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic              inflight;
    logic              done_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic issue;
    logic push;
    logic pop;
    logic kill;
    logic accept;
    logic last_pop;

    // Reads in flight are counted against FIFO space so a return always has a slot.
    assign issue    = (state == RUN) && (issue_cnt != '0) &&
                      ((fifo_count + CNT_W'(inflight)) < DEPTH_C);
    assign push     = inflight;
    assign pop      = m_valid_o && m_ready_i;
    assign kill     = abort_i && (state != IDLE);
    assign accept   = (state == IDLE) && start_i && !abort_i && (len_i != '0);
    assign last_pop = pop && (out_cnt == ONE_C);

    assign ram_clk1  = wb_clk_i;
    assign ram_csb1  = ~issue;
    assign ram_addr1 = rd_addr;
    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;
    assign m_valid_o = (fifo_count != '0);
    assign m_data_o  = m_valid_o ? fifo_mem[rd_ptr] : '0;
    assign m_last_o  = m_valid_o && (out_cnt == ONE_C);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= IDLE;
            rd_addr    <= '0;
            issue_cnt  <= '0;
            out_cnt    <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                // The pending SRAM return is dropped by clearing inflight.
                state      <= IDLE;
                inflight   <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    rd_addr   <= rd_addr + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    out_cnt <= out_cnt - 1'b1;
                end
                if (push && !pop)      fifo_count <= fifo_count + 1'b1;
                else if (pop && !push) fifo_count <= fifo_count - 1'b1;

                case (state)
                    IDLE: if (accept) begin
                        rd_addr   <= base_addr_i;
                        issue_cnt <= len_i;
                        out_cnt   <= len_i;
                        state     <= RUN;
                    end
                    RUN: if (issue && issue_cnt == ONE_C) state <= DRAIN;
                    DRAIN: if (last_pop) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: FIFO storage has no reset; pointers/count define validity and the head is gated by m_valid_o.
    always_ff @(posedge wb_clk_i) begin
        if (push && !kill) fifo_mem[wr_ptr] <= ram_dout1;
    end

`ifdef RAM_STREAM_CSUM_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)         csum_o <= '0;
        else if (accept)        csum_o <= '0;
        else if (pop && !kill)  csum_o <= csum_o + m_data_o;
    end
`endif

endmodule

// File: tb/tb_ram_port1_streamer.sv
// Directed bench for ram_port1_streamer with a behavioural 1R SRAM and a
// negedge monitor that logs issued addresses, handshakes and done pulses.
module tb_ram_port1_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        ram_clk1;
    logic        ram_csb1;
    logic [7:0]  ram_addr1;
    logic [31:0] ram_dout1;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
`ifdef RAM_STREAM_CSUM_EN
    logic [31:0] csum;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram [256];
    logic [31:0] hs_data [$];
    logic        hs_last [$];
    logic [7:0]  iss_addr [$];
    int          done_cnt = 0;

    ram_port1_streamer dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .base_addr_i (base_addr),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .ram_clk1    (ram_clk1),
        .ram_csb1    (ram_csb1),
        .ram_addr1   (ram_addr1),
        .ram_dout1   (ram_dout1),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_last_o    (m_last)
`ifdef RAM_STREAM_CSUM_EN
        ,
        .csum_o      (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [7:0] a);
        case (a)
            8'h80:   return 32'h0000_0001;
            8'h81:   return 32'h0000_0002;
            8'h82:   return 32'h0000_0003;
            8'h83:   return 32'hFFFF_FFFF;
            default: return 32'h100 + {24'h0, a};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = word_at(8'(i));
        ram_dout1 = '0;
    end

    always @(posedge clk) begin
        if (!ram_csb1) ram_dout1 <= ram[ram_addr1];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_last.push_back(m_last);
            end
            if (!ram_csb1) iss_addr.push_back(ram_addr1);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        hs_data.delete();
        hs_last.delete();
        iss_addr.delete();
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        check(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] b, input int n);
        check({tag, "_count"}, 64'(hs_data.size()), 64'(n));
        for (int i = 0; i < hs_data.size() && i < n; i++) begin
            check({tag, "_data"}, 64'(hs_data[i]), 64'(word_at(8'(b + i))));
            check({tag, "_last"}, 64'(hs_last[i]), 64'(i == n - 1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        #23;
        check("rst_csb",   64'(ram_csb1),  64'd1);
        check("rst_addr",  64'(ram_addr1), 64'd0);
        check("rst_valid", 64'(m_valid),   64'd0);
        check("rst_data",  64'(m_data),    64'd0);
        check("rst_last",  64'(m_last),    64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
`ifdef RAM_STREAM_CSUM_EN
        check("rst_csum",  64'(csum),      64'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Cycle-accurate basic transfer: base 0x10, len 4.
        clear_log();
        start_xfer(8'h10, 9'd4);
        check("t1_busy",    64'(busy),      64'd1);
        check("t1_csb0",    64'(ram_csb1),  64'd0);
        check("t1_addr0",   64'(ram_addr1), 64'h10);
        check("t1_valid_t", 64'(m_valid),   64'd0);
        tick();
        check("t1_valid_t1", 64'(m_valid),  64'd0);
        check("t1_addr1",    64'(ram_addr1), 64'h11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", 64'(m_valid), 64'd1);
            check("t1_data",  64'(m_data),  64'h110 + 64'(i));
            check("t1_last",  64'(m_last),  64'(i == 3));
            check("t1_done_early", 64'(done), 64'd0);
        end
        tick();
        check("t1_valid_end", 64'(m_valid), 64'd0);
        check("t1_done",      64'(done),    64'd1);
        check("t1_busy_end",  64'(busy),    64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_iss_count",  64'(iss_addr.size()), 64'd4);

        // Address wrap 0xFE..0x01.
        clear_log();
        start_xfer(8'hFE, 9'd4);
        wait_done("t2_done");
        check("t2_iss_count", 64'(iss_addr.size()), 64'd4);
        for (int i = 0; i < iss_addr.size() && i < 4; i++)
            check("t2_iss_addr", 64'(iss_addr[i]), 64'(8'(8'hFE + i)));
        check_stream("t2", 8'hFE, 4);

        // Back-pressure: len 8 with the sink stalled for 10 cycles.
        clear_log();
        m_ready = 1'b0;
        start_xfer(8'h20, 9'd8);
        repeat (10) tick();
        check("t3_iss_stall", 64'(iss_addr.size()), 64'd4);
        check("t3_csb_stall", 64'(ram_csb1), 64'd1);
        check("t3_hs_stall",  64'(hs_data.size()), 64'd0);
        m_ready = 1'b1;
        check("t3_csb_rise",  64'(ram_csb1), 64'd1);
        tick();
        check("t3_csb_resume",  64'(ram_csb1),  64'd0);
        check("t3_addr_resume", 64'(ram_addr1), 64'h24);
        wait_done("t3_done");
        check("t3_iss_total", 64'(iss_addr.size()), 64'd8);
        check_stream("t3", 8'h20, 8);

        // Abort in the third RUN cycle, then a fresh transfer.
        clear_log();
        start_xfer(8'h40, 9'd8);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy",  64'(busy),     64'd0);
        check("t4_valid", 64'(m_valid),  64'd0);
        check("t4_csb",   64'(ram_csb1), 64'd1);
        begin
            int d0;
            d0 = done_cnt;
            tick();
            check("t4_valid_late", 64'(m_valid), 64'd0);
            repeat (3) tick();
            check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        end
        clear_log();
        start_xfer(8'h50, 9'd3);
        wait_done("t4b_done");
        check_stream("t4b", 8'h50, 3);

        // len 0 is a no-op.
        clear_log();
        begin
            int d0;
            d0 = done_cnt;
            start_xfer(8'h30, 9'd0);
            check("t5_busy", 64'(busy), 64'd0);
            repeat (4) tick();
            check("t5_iss",  64'(iss_addr.size()), 64'd0);
            check("t5_done", 64'(done_cnt - d0), 64'd0);
        end

        // start while busy is ignored.
        clear_log();
        m_ready = 1'b0;
        start_xfer(8'h60, 9'd2);
        tick();
        start_xfer(8'h70, 9'd5);
        m_ready = 1'b1;
        wait_done("t6_done");
        repeat (4) tick();
        check("t6_busy_after", 64'(busy), 64'd0);
        check_stream("t6", 8'h60, 2);

        // Checksum words 1, 2, 3, 0xFFFFFFFF.
        clear_log();
        start_xfer(8'h80, 9'd4);
`ifdef RAM_STREAM_CSUM_EN
        check("t7_csum_clr", 64'(csum), 64'd0);
`endif
        wait_done("t7_done");
        check_stream("t7", 8'h80, 4);
`ifdef RAM_STREAM_CSUM_EN
        check("t7_csum", 64'(csum), 64'h5);
        repeat (3) tick();
        check("t7_csum_hold", 64'(csum), 64'h5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
